// File: rtl/serial_pkg.sv
// Shared types and constants for the dual-word serializer.
// State encoding and counter widths used by the top-level FSM.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      SHIFT,
      GAP
   } state_t;

   localparam int SER_W = 8;
   localparam int GAP_W = 4;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register with a registered serial output.
// q carries the head bit in the cycle after each shift, else 0.
module piso_shift_reg #(
   parameter int W         = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] d,
   output logic         q
);

   logic [W-1:0] r_sr;
   logic         r_q;
   logic         w_head;
   logic [W-1:0] w_next;

   // Select head bit and shifted image for the configured bit order
   always_comb begin
      if (MSB_FIRST) begin
         w_head = r_sr[W-1];
         w_next = {r_sr[W-2:0], 1'b0};
      end else begin
         w_head = r_sr[0];
         w_next = {1'b0, r_sr[W-1:1]};
      end
   end

   // Load a word, or move the head into the output flop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sr <= '0;
         r_q  <= 1'b0;
      end else if (load) begin
         r_sr <= d;
         r_q  <= 1'b0;
      end else if (shift) begin
         r_sr <= w_next;
         r_q  <= w_head;
      end else begin
         r_q  <= 1'b0;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/dual_word_serializer.sv
// Feeds two operands bit-serially, in lock-step, to a magnitude comparator.
// Frame: CLEAR pulse, W bit pairs, optional idle gap, then ready again.
module dual_word_serializer
   import serial_pkg::*;
#(
   parameter int W          = SER_W,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int GAP_CYCLES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a_word,
   input  logic [W-1:0] b_word,
   output logic         cmp_clear,
   output logic         a,
   output logic         b,
   output logic         bit_valid,
   output logic         first_bit,
   output logic         last_bit,
   output logic         frame_done
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
   localparam logic [GAP_W-1:0] GAP_LAST =
      (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [GAP_W-1:0] r_gap;
   logic [GAP_W-1:0] w_gap_nxt;

   logic r_in_ready;
   logic r_cmp_clear;
   logic r_bit_valid;
   logic r_first;
   logic r_last;
   logic r_frame_done;

   logic w_hs;
   logic w_shift_en;

   assign w_hs       = (r_state == IDLE) && r_in_ready && in_valid;
   assign w_shift_en = (w_state_nxt == SHIFT);

   // Next-state and counter logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_gap_nxt   = r_gap;
      unique case (r_state)
         IDLE: begin
            if (w_hs) begin
               w_state_nxt = CLEAR;
               w_cnt_nxt   = '0;
            end
         end
         CLEAR: begin
            w_state_nxt = SHIFT;
            w_cnt_nxt   = '0;
         end
         SHIFT: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt   = '0;
               w_gap_nxt   = '0;
               w_state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         GAP: begin
            if (r_gap == GAP_LAST) begin
               w_state_nxt = IDLE;
            end else begin
               w_gap_nxt = r_gap + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_gap   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gap   <= w_gap_nxt;
      end
   end

   // Outputs are registered from the state being entered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_in_ready   <= 1'b0;
         r_cmp_clear  <= 1'b0;
         r_bit_valid  <= 1'b0;
         r_first      <= 1'b0;
         r_last       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_in_ready   <= (w_state_nxt == IDLE);
         r_cmp_clear  <= (w_state_nxt == CLEAR);
         r_bit_valid  <= w_shift_en;
         r_first      <= w_shift_en && (w_cnt_nxt == '0);
         r_last       <= w_shift_en && (w_cnt_nxt == CNT_LAST);
         r_frame_done <= r_last;
      end
   end

   piso_shift_reg #(
      .W         (W),
      .MSB_FIRST (MSB_FIRST)
   ) u_sr_a (
      .clk   (clk),
      .reset (reset),
      .load  (w_hs),
      .shift (w_shift_en),
      .d     (a_word),
      .q     (a)
   );

   piso_shift_reg #(
      .W         (W),
      .MSB_FIRST (MSB_FIRST)
   ) u_sr_b (
      .clk   (clk),
      .reset (reset),
      .load  (w_hs),
      .shift (w_shift_en),
      .d     (b_word),
      .q     (b)
   );

   assign in_ready   = r_in_ready;
   assign cmp_clear  = r_cmp_clear;
   assign bit_valid  = r_bit_valid;
   assign first_bit  = r_first;
   assign last_bit   = r_last;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_dual_word_serializer.sv
// Bench for dual_word_serializer: three configurations driven in parallel.
// A frame-timeline model predicts every output on every cycle.
module tb_dual_word_serializer;

   localparam int W = 8;
   localparam int GAPC [3] = '{2, 2, 0};
   localparam bit MSBF [3] = '{1'b1, 1'b0, 1'b1};

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [2:0]   in_valid = '0;
   logic [W-1:0] aw [3] = '{default: '0};
   logic [W-1:0] bw [3] = '{default: '0};

   logic [2:0] in_ready, cmp_clear, sa, sb;
   logic [2:0] bit_valid, first_bit, last_bit, frame_done;

   int tests = 0;
   int fails = 0;
   int n = 0;

   int           h [3]     = '{-1, -1, -1};
   int           since [3] = '{0, 0, 0};
   logic [W-1:0] ma [3]    = '{default: '0};
   logic [W-1:0] mb [3]    = '{default: '0};

   logic [W-1:0] seq_a [3] = '{default: '0};
   logic [W-1:0] seq_b [3] = '{default: '0};
   int fd_n [3]      = '{0, 0, 0};
   int clr_n [3]     = '{0, 0, 0};
   int rdy_n [3]     = '{0, 0, 0};
   int bits_post [3] = '{0, 0, 0};
   logic [2:0] rdy_prev = '0;

   int hs, hm, h2;

   always #5 clk = ~clk;

   dual_word_serializer #(.W(W), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u0 (
      .clk(clk), .reset(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a_word(aw[0]), .b_word(bw[0]),
      .cmp_clear(cmp_clear[0]), .a(sa[0]), .b(sb[0]),
      .bit_valid(bit_valid[0]), .first_bit(first_bit[0]),
      .last_bit(last_bit[0]), .frame_done(frame_done[0]));

   dual_word_serializer #(.W(W), .MSB_FIRST(1'b0), .GAP_CYCLES(2)) u1 (
      .clk(clk), .reset(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a_word(aw[1]), .b_word(bw[1]),
      .cmp_clear(cmp_clear[1]), .a(sa[1]), .b(sb[1]),
      .bit_valid(bit_valid[1]), .first_bit(first_bit[1]),
      .last_bit(last_bit[1]), .frame_done(frame_done[1]));

   dual_word_serializer #(.W(W), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u2 (
      .clk(clk), .reset(rst),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .a_word(aw[2]), .b_word(bw[2]),
      .cmp_clear(cmp_clear[2]), .a(sa[2]), .b(sb[2]),
      .bit_valid(bit_valid[2]), .first_bit(first_bit[2]),
      .last_bit(last_bit[2]), .frame_done(frame_done[2]));

   task automatic chk(int i, string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL u%0d %s: got %0h want %0h (edge %0d)",
                  i, nm, act, exp, n);
      end
   endtask

   task automatic tick(int k);
      repeat (k) begin
         @(posedge clk);
         #2;
      end
   endtask

   function automatic logic bitsel(logic [W-1:0] w, int k, bit msb);
      if (k < 0 || k >= W) return 1'b0;
      return msb ? w[W-1-k] : w[k];
   endfunction

   function automatic bit mready(int i, int nn);
      return since[i] >= 1 && (h[i] < 0 || nn - h[i] >= W + 1 + GAPC[i]);
   endfunction

   // Model: count edges, record handshakes and captured words
   always @(posedge clk) begin
      bit cur [3];
      for (int i = 0; i < 3; i++) cur[i] = !rst && mready(i, n);
      n = n + 1;
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            h[i] = -1;
            since[i] = 0;
         end else begin
            since[i]++;
            if (cur[i] && in_valid[i]) begin
               h[i] = n;
               ma[i] = aw[i];
               mb[i] = bw[i];
            end
         end
      end
   end

   // Compare every output of every instance against the timeline
   always @(negedge clk) begin
      int d, k;
      bit live, e_bv;
      for (int i = 0; i < 3; i++) begin
         d = n - h[i];
         k = d - 1;
         live = !rst && h[i] >= 0;
         e_bv = live && d >= 1 && d <= W;
         chk(i, "in_ready", in_ready[i],
             !rst && mready(i, n));
         chk(i, "cmp_clear", cmp_clear[i], live && d == 0);
         chk(i, "bit_valid", bit_valid[i], e_bv);
         chk(i, "a", sa[i], e_bv ? bitsel(ma[i], k, MSBF[i]) : 1'b0);
         chk(i, "b", sb[i], e_bv ? bitsel(mb[i], k, MSBF[i]) : 1'b0);
         chk(i, "first_bit", first_bit[i], e_bv && k == 0);
         chk(i, "last_bit", last_bit[i], e_bv && k == W - 1);
         chk(i, "frame_done", frame_done[i], live && d == W + 1);
      end
   end

   // Collect serial streams and event times for literal checks
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) bits_post[i] = 0;
         else if (bit_valid[i]) bits_post[i]++;
         if (bit_valid[i]) begin
            if (first_bit[i]) begin
               seq_a[i] = {{(W-1){1'b0}}, sa[i]};
               seq_b[i] = {{(W-1){1'b0}}, sb[i]};
            end else begin
               seq_a[i] = {seq_a[i][W-2:0], sa[i]};
               seq_b[i] = {seq_b[i][W-2:0], sb[i]};
            end
         end
         if (frame_done[i]) fd_n[i] = n;
         if (cmp_clear[i]) clr_n[i] = n;
         if (in_ready[i] && !rdy_prev[i]) rdy_n[i] = n;
         rdy_prev[i] = in_ready[i];
      end
   end

   initial begin
      tick(3);
      rst = 1'b0;
      tick(4);

      aw[0] = 8'hA5; bw[0] = 8'h5A;
      aw[1] = 8'h01; bw[1] = 8'h80;
      aw[2] = 8'h33; bw[2] = 8'h33;
      in_valid = 3'b111;
      hs = n + 1;
      tick(1);
      in_valid[1:0] = 2'b00;
      aw[2] = 8'h00; bw[2] = 8'hFF;
      tick(3);
      in_valid[2] = 1'b0;
      tick(2);
      in_valid[2] = 1'b1;
      tick(5);
      in_valid[2] = 1'b0;
      tick(14);

      chk(0, "seq_a A5", seq_a[0], 8'hA5);
      chk(0, "seq_b 5A", seq_b[0], 8'h5A);
      chk(0, "frame_done lat", fd_n[0], hs + 9);
      chk(0, "ready lat", rdy_n[0], hs + 11);
      chk(1, "lsb seq_a", seq_a[1], 8'h80);
      chk(1, "lsb seq_b", seq_b[1], 8'h01);
      chk(2, "b2b 2nd clear", clr_n[2], hs + 10);
      chk(2, "b2b 2nd done", fd_n[2], hs + 19);
      chk(2, "b2b seq_a", seq_a[2], 8'h00);
      chk(2, "b2b seq_b", seq_b[2], 8'hFF);

      aw[0] = 8'hC3; bw[0] = 8'h3C;
      in_valid[0] = 1'b1;
      hm = n + 1;
      tick(1);
      in_valid[0] = 1'b0;
      tick(3);
      chk(0, "pre-rst bit_valid", bit_valid[0], 1'b1);
      rst = 1'b1;
      #1;
      chk(0, "async bit_valid", bit_valid[0], 1'b0);
      chk(0, "async in_ready", in_ready[0], 1'b0);
      chk(0, "async a", sa[0], 1'b0);
      chk(0, "async b", sb[0], 1'b0);
      tick(2);
      rst = 1'b0;
      tick(12);
      chk(0, "no bits after rst", bits_post[0], 0);
      chk(0, "ready after rst", in_ready[0], 1'b1);

      aw[0] = 8'h96; bw[0] = 8'h69;
      aw[1] = 8'hFF; bw[1] = 8'hFF;
      in_valid[1:0] = 2'b11;
      h2 = n + 1;
      tick(1);
      in_valid[1:0] = 2'b00;
      tick(14);
      chk(0, "post-rst clear", clr_n[0], h2);
      chk(0, "post-rst done", fd_n[0], h2 + 9);
      chk(0, "post-rst seq_a", seq_a[0], 8'h96);
      chk(0, "post-rst seq_b", seq_b[0], 8'h69);
      chk(1, "equal seq_a", seq_a[1], 8'hFF);
      chk(1, "equal seq_b", seq_b[1], 8'hFF);
      chk(0, "mid-frame edge", hm > 0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dual_word_serializer.md
Name: dual_word_serializer

Overview:
- Upstream feeder for the bit-serial magnitude comparator.
- Accepts two parallel W-bit operands through a valid/ready handshake and issues a one-cycle comparator clear.
- Then shifts both operands out in lock-step, one bit pair per clock, on serial lines a/b, followed by a programmable idle gap so the comparator flags can be sampled.
- Framing strobes let the downstream stage and the bench delimit each comparison.

Parameters:
- W, 8, operand width in bits (legal range 2..32).
- MSB_FIRST, 1, 1 = bit W-1 shifted first; 0 = bit 0 first.
- GAP_CYCLES, 2, idle cycles after the last bit before the next operand is accepted (legal range 0..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair present on a_word/b_word.
- in_ready  output  1  block can accept a pair.
- a_word  input  W  operand A.
- b_word  input  W  operand B.
- cmp_clear  output  1  one-cycle clear pulse to the comparator, issued before the first bit.
- a  output  1  serial bit of A.
- b  output  1  serial bit of B.
- bit_valid  output  1  a/b carry a valid bit this cycle.
- first_bit  output  1  current bit is the first of the frame.
- last_bit  output  1  current bit is the last of the frame.
- frame_done  output  1  one-cycle pulse in the cycle after last_bit.

Behaviour:
- All outputs are registered.
- Reset asserted, at any time including mid-frame: state=IDLE, shift registers and counter cleared, every output 0 (in_ready included). The partial frame is discarded and nothing is resumed.
- First rising clk after reset release: in_ready=1.
- FSM states: IDLE, CLEAR, SHIFT, GAP.
- IDLE:
  - in_ready=1.
  - Handshake completes on a clk edge where in_valid=1 and in_ready=1. Both words are captured into internal shift registers, counter=0, next state=CLEAR.
  - in_valid is ignored when in_ready=0.
  - Operand inputs are sampled only at the handshake edge.
- CLEAR (exactly 1 cycle): cmp_clear=1, in_ready=0, bit_valid=0, next state=SHIFT.
- SHIFT (exactly W cycles):
  - bit_valid=1.
  - a/b = current head bit of each shift register: bit W-1-k when MSB_FIRST=1, bit k when MSB_FIRST=0, for k = counter value.
  - first_bit=1 when counter=0; last_bit=1 when counter=W-1.
  - Counter increments each cycle and does not wrap inside a frame.
  - After counter=W-1: next state=GAP if GAP_CYCLES>0, else IDLE.
- GAP (GAP_CYCLES cycles): bit_valid=0, a=b=0, in_ready=0, then IDLE.
- frame_done=1 for exactly the one cycle after last_bit, whether that cycle is in GAP or in IDLE.
- Outside SHIFT: a, b, first_bit and last_bit are all 0.
- Latency, handshake at edge t:
  - cmp_clear high in cycle t+1.
  - Bits in cycles t+2 .. t+W+1.
  - frame_done in cycle t+W+2.
  - in_ready=1 from cycle t+W+2+GAP_CYCLES.
  - Throughput is one pair per W+2+GAP_CYCLES cycles.
- in_valid held high continuously: the next pair is accepted on the first IDLE edge, giving back-to-back frames with no extra bubble.
- Counter width is clog2(W) bits; a comparison against W-1 ends the frame.

Decomposition:
- Shared package (serial_pkg):
  - State enum {IDLE, CLEAR, SHIFT, GAP}.
  - Default width constant SER_W=8.
  - Constant GAP_W=4 for the gap counter.
- One natural sub-module: piso_shift_reg (params W, MSB_FIRST).
  - Ports: clk, reset, load, shift, d[W-1:0], q.
  - Instantiated twice, once for A and once for B.
- FSM and counters stay in the top module.

Test Plan:
- Reset then idle: hold reset 3 cycles, release. All outputs 0 during reset; in_ready=1 one clk after release; no activity with in_valid=0.
- Basic frame, W=8, MSB_FIRST=1, A=0xA5, B=0x5A, handshake at edge t:
  - cmp_clear only in t+1.
  - a sequence 1,0,1,0,0,1,0,1 and b sequence 0,1,0,1,1,0,1,0 in t+2..t+9.
  - first_bit at t+2, last_bit at t+9, frame_done at t+10, in_ready at t+12.
  - With the comparator attached, agreatb=1 after the frame.
- LSB-first, MSB_FIRST=0, A=0x01, B=0x80: a sequence 1,0,0,0,0,0,0,0; b sequence 0,0,0,0,0,0,0,1.
- Back-to-back, GAP_CYCLES=0, in_valid held high with pairs (0x33,0x33) then (0x00,0xFF):
  - Second handshake at t+10.
  - Frames separated only by its CLEAR cycle.
  - in_valid changes while in_ready=0 are ignored.
- Reset mid-frame: assert reset after 3 SHIFT bits. All outputs drop to 0 asynchronously, before the next clk edge. After release, no remaining bits are emitted and a new pair starts a clean frame with cmp_clear.
- Equal operands A=B=0xFF: a and b identical in every bit cycle; comparator aequalb=1 after frame_done.
